jk_bank_arbiter: RTL and testbench
==================================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, bit count of the controlled JK flip-flop bank.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0 / req1  input  1 each  requester 0/1 transaction request, level, held high until own gnt.
REQ-005 op0 / op1  input  2 each  opcode: 00 HOLD(read), 01 CLEAR, 10 SET, 11 TOGGLE.
REQ-006 mask0 / mask1  input  WIDTH each  bit select for op.
REQ-007 q  input  WIDTH  current bank outputs.
REQ-008 j / k  output  WIDTH each  registered J/K drive to bank.
REQ-009 gnt0 / gnt1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-010 rdata  output  WIDTH  bank value captured after the operation, valid while gnt pulses and held until next capture.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, APPLY, SETTLE, DONE; fixed sequence IDLE->APPLY->SETTLE->DONE->IDLE once a request is accepted.
REQ-013 IDLE: with any req high, latch winner's op, mask and id, go to APPLY; else stay, j=k=0.
REQ-014 Arbitration: one request -> served; both -> requester not served last (round-robin pointer updated on accept).
REQ-015 APPLY (exactly one cycle): HOLD j=0,k=0; CLEAR j=0,k=mask; SET j=mask,k=0; TOGGLE j=mask,k=mask.
REQ-016 Bits outside mask: j=k=0 always (bank holds those bits).
REQ-017 SETTLE: j=k=0; rdata<=q at end of SETTLE.
REQ-018 DONE: gnt of latched id high for exactly this cycle, other gnt low; gnt0 and gnt1 never high together.
REQ-019 Latency: request sampled at edge E -> j/k valid cycle after E -> gnt high 3 cycles after E; next accept no earlier than the IDLE cycle after DONE.
REQ-020 Requester drops req at the edge ending its gnt cycle; req high in IDLE is a new request.
REQ-021 Changes to op/mask/req after accept ignored until return to IDLE.
REQ-022 Requests arriving while busy wait, no loss; arbitration considers them only in IDLE.

Reset
REQ-023 rst_n low at a rising edge, any state, incl. mid-transaction: next state IDLE, j=0, k=0, gnt0=gnt1=0, rdata=0, busy=0, pending transaction discarded.
REQ-024 Reset sets round-robin pointer so requester 0 wins first simultaneous contest.
REQ-025 Reset has priority over all other inputs.

Configuration
REQ-026 Macro JKC_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests, pointer logic absent.
REQ-027 Macro undefined: round-robin per REQ-014.
REQ-028 Ports, FSM and latency identical in both builds.

Verification (WIDTH=8, bank model = JK flops on clk)
REQ-029 rst_n low 2 cycles mid-traffic -> j=k=0x00, gnt0=gnt1=0, rdata=0x00, busy=0.
REQ-030 Bank q=0x00, req0 SET mask 0x0F -> APPLY j=0x0F k=0x00 one cycle; gnt0 pulse 3 cycles after sample; rdata=0x0F.
REQ-031 q=0x0F, same-cycle req0 TOGGLE 0xFF and req1 CLEAR 0xF0 -> req0 first, rdata=0xF0, gnt0; then req1, rdata=0x00, gnt1; repeated contests alternate.
REQ-032 q=0x5A, req1 HOLD mask 0xAA -> j=k=0x00 throughout, gnt1 pulse, rdata=0x5A, q unchanged.
REQ-033 rst_n low during APPLY -> next cycle IDLE, j=k=0x00, no gnt for aborted transaction.
REQ-034 JKC_FIXED_PRIO_EN defined, req0 and req1 both held continuously -> gnt0 every transaction, gnt1 never.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - two-requester arbiter driving a JK flip-flop bank (optional macro: JKC_FIXED_PRIO_EN)
module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask0,
    input  logic [WIDTH-1:0] mask1,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_id;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_gnt0;
    logic             r_gnt1;
    logic [WIDTH-1:0] r_rdata;

    logic             w_any_req;
    logic             w_accept;
    logic             w_win_id;
    logic [1:0]       w_win_op;
    logic [WIDTH-1:0] w_win_mask;
    logic [WIDTH-1:0] w_j_d;
    logic [WIDTH-1:0] w_k_d;
    logic             w_gnt0_d;
    logic             w_gnt1_d;

    assign w_any_req = req0 | req1;
    assign w_accept  = (r_state == S_IDLE) && w_any_req;

`ifdef JKC_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks; requester 1 only when alone.
    assign w_win_id = ~req0;
`else
    logic r_ptr;

    // On a tie the pointer picks; a lone requester always wins.
    assign w_win_id = (req0 && req1) ? r_ptr : req1;

    // Pointer favours the requester not served by the latest accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_win_id;
        end
    end
`endif

    assign w_win_op   = w_win_id ? op1   : op0;
    assign w_win_mask = w_win_id ? mask1 : mask0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fixed four-step walk once a request is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_APPLY;
            S_APPLY:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: op bit 1 drives J, op bit 0 drives K, both gated by the mask,
    // so the opcode and mask are captured straight into the J/K registers at accept.
    always_comb begin
        w_j_d    = '0;
        w_k_d    = '0;
        w_gnt0_d = 1'b0;
        w_gnt1_d = 1'b0;
        if (w_accept) begin
            w_j_d = w_win_op[1] ? w_win_mask : '0;
            w_k_d = w_win_op[0] ? w_win_mask : '0;
        end
        if (r_state == S_SETTLE) begin
            w_gnt0_d = ~r_id;
            w_gnt1_d = r_id;
        end
    end

    // Registered outputs, winner id and read-back capture at the end of SETTLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id    <= 1'b0;
            r_j     <= '0;
            r_k     <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_j    <= w_j_d;
            r_k    <= w_k_d;
            r_gnt0 <= w_gnt0_d;
            r_gnt1 <= w_gnt1_d;
            if (w_accept) begin
                r_id <= w_win_id;
            end
            if (r_state == S_SETTLE) begin
                r_rdata <= q;
            end
        end
    end

    assign j     = r_j;
    assign k     = r_k;
    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign rdata = r_rdata;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - scoreboard bench for jk_bank_arbiter with a JK bank model
module tb_jk_bank_arbiter;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] mask0, mask1;
    logic [7:0] q;
    logic [7:0] j, k;
    logic       gnt0, gnt1;
    logic [7:0] rdata;
    logic       busy;

    logic       bank_load;
    logic [7:0] bank_val;

    typedef struct {
        logic       id;
        logic [7:0] rdata;
        logic [7:0] j;
        logic [7:0] k;
    } exp_t;

    exp_t sb[$];

    int n_checks;
    int n_errors;

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .op0   (op0),
        .op1   (op1),
        .mask0 (mask0),
        .mask1 (mask1),
        .q     (q),
        .j     (j),
        .k     (k),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .rdata (rdata),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // JK bank model with a preload port
    always @(posedge clk) begin
        if (bank_load) q <= bank_val;
        else           q <= (j & ~q) | (~k & q);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [7:0] rd, input logic [7:0] ej, input logic [7:0] ek);
        exp_t e;
        e.id = id; e.rdata = rd; e.j = ej; e.k = ek;
        sb.push_back(e);
    endtask

    task automatic load_bank(input logic [7:0] v);
        bank_load = 1'b1;
        bank_val  = v;
        @(posedge clk); #1;
        bank_load = 1'b0;
    endtask

    // Requester model: drop req on the edge ending its grant, optionally re-raise at once
    task automatic serve(input int n_tx, input bit rearm);
        int got = 0;
        int cyc = 0;
        logic d0, d1;
        while (got < n_tx && cyc < 200) begin
            @(negedge clk);
            cyc++;
            d0 = gnt0;
            d1 = gnt1;
            @(posedge clk); #1;
            if (d0) begin req0 = 1'b0; got++; if (rearm && got < n_tx) req0 = 1'b1; end
            if (d1) begin req1 = 1'b0; got++; if (rearm && got < n_tx) req1 = 1'b1; end
        end
        check("serve_timeout", got, n_tx);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_j"},     j,     8'h00);
        check({tag, "_k"},     k,     8'h00);
        check({tag, "_gnt0"},  gnt0,  1'b0);
        check({tag, "_gnt1"},  gnt1,  1'b0);
        check({tag, "_busy"},  busy,  1'b0);
    endtask

    // Monitor: captures APPLY drive, checks quiet J/K afterwards, pops on every grant
    initial begin
        logic       prev_busy;
        int         cnt;
        logic [7:0] apply_j, apply_k;
        exp_t       e;
        prev_busy = 1'b0;
        cnt = 0;
        apply_j = '0;
        apply_k = '0;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (!prev_busy) begin
                    cnt = 0;
                    apply_j = j;
                    apply_k = k;
                end else begin
                    cnt++;
                    check("jk_quiet_after_apply", {j, k}, 16'h0000);
                end
            end
            if (gnt0 || gnt1) begin
                check("gnt_exclusive", gnt0 & gnt1, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_gnt", {gnt1, gnt0}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("gnt_id",      gnt1,    e.id);
                    check("rdata",       rdata,   e.rdata);
                    check("apply_j",     apply_j, e.j);
                    check("apply_k",     apply_k, e.k);
                    check("gnt_latency", cnt,     2);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        op0       = OP_HOLD;
        op1       = OP_HOLD;
        mask0     = '0;
        mask1     = '0;
        bank_load = 1'b1;
        bank_val  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_rdata", rdata, 8'h00);
        @(posedge clk); #1;
        bank_load = 1'b0;

        // Single SET from requester 0
        load_bank(8'h00);
        op0 = OP_SET; mask0 = 8'h0F; req0 = 1'b1;
        push(1'b0, 8'h0F, 8'h0F, 8'h00);
        serve(1, 1'b0);

        // Request arriving while busy waits; requester 0 changes op after accept
        load_bank(8'h00);
        op0 = OP_SET; mask0 = 8'h0F; req0 = 1'b1;
        @(posedge clk); #1;
        op0 = OP_TOGGLE; mask0 = 8'hFF;
        op1 = OP_SET; mask1 = 8'hF0; req1 = 1'b1;
        push(1'b0, 8'h0F, 8'h0F, 8'h00);
        push(1'b1, 8'hFF, 8'hF0, 8'h00);
        serve(2, 1'b0);

        // HOLD from requester 1 leaves the bank untouched
        load_bank(8'h5A);
        op1 = OP_HOLD; mask1 = 8'hAA; req1 = 1'b1;
        push(1'b1, 8'h5A, 8'h00, 8'h00);
        serve(1, 1'b0);
        check("hold_q_unchanged", q, 8'h5A);

        // Reset held two cycles in the middle of a transaction
        op0 = OP_SET; mask0 = 8'h01; req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        check("midreset_rdata", rdata, 8'h00);

        // Reset during APPLY aborts without a grant
        op1 = OP_SET; mask1 = 8'hFF; req1 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("applyreset");
        repeat (6) @(posedge clk);
        #1;

        // Simultaneous contests with both requesters held continuously
        load_bank(8'h0F);
        op0 = OP_TOGGLE; mask0 = 8'hFF;
        op1 = OP_CLEAR;  mask1 = 8'hF0;
`ifdef JKC_FIXED_PRIO_EN
        push(1'b0, 8'hF0, 8'hFF, 8'hFF);
        push(1'b0, 8'h0F, 8'hFF, 8'hFF);
        push(1'b0, 8'hF0, 8'hFF, 8'hFF);
        push(1'b0, 8'h0F, 8'hFF, 8'hFF);
`else
        push(1'b0, 8'hF0, 8'hFF, 8'hFF);
        push(1'b1, 8'h00, 8'h00, 8'hF0);
        push(1'b0, 8'hFF, 8'hFF, 8'hFF);
        push(1'b1, 8'h0F, 8'h00, 8'hF0);
`endif
        req0 = 1'b1; req1 = 1'b1;
        serve(4, 1'b1);
        req0 = 1'b0; req1 = 1'b0;

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
